// File: rtl/mult_scheduler.sv
// Round-robin front end for one shared pipelined multiplier: picks one requester
// per cycle, registers its operands, and tags each issue so the product is returned with its owner's id.
module mult_scheduler #(
    parameter int BITSIZE = 16,
    parameter int NREQ    = 4,
    parameter int LATENCY = 2,
    localparam int IDW    = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*BITSIZE-1:0]   in1,
    input  logic [NREQ*BITSIZE-1:0]   in2,
    output logic [NREQ-1:0]           grant,
    output logic [BITSIZE-1:0]        mul_in1,
    output logic [BITSIZE-1:0]        mul_in2,
    input  logic [BITSIZE-1:0]        mul_out,
    output logic [BITSIZE-1:0]        res_data,
    output logic                      res_valid,
    output logic [IDW-1:0]            res_id
);

    logic [BITSIZE-1:0] opA [NREQ];
    logic [BITSIZE-1:0] opB [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign opA[g] = in1[g*BITSIZE +: BITSIZE];
        assign opB[g] = in2[g*BITSIZE +: BITSIZE];
    end

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [IDW-1:0]     sel_d;
    logic               found_d;
    logic [IDW:0]       cand;
    logic [IDW:0]       nxt;
    logic [NREQ-1:0]    grant_q, grant_d;
    logic [BITSIZE-1:0] mulIn1_q, mulIn2_q;
    logic [BITSIZE-1:0] resData_q;
    logic               resValid_q;
    logic [IDW-1:0]     resId_q;
    logic [LATENCY:0]   tagV_q;
    logic [IDW-1:0]     tagId_q [LATENCY+1];

    // Search starts at the pointer and wraps, so the first hit is the round-robin winner.
    always_comb begin
        found_d = 1'b0;
        sel_d   = '0;
        cand    = '0;
        for (int k = 0; k < NREQ; k++) begin
            cand = {1'b0, ptr_q} + (IDW+1)'(k);
            if (cand >= (IDW+1)'(NREQ))
                cand = cand - (IDW+1)'(NREQ);
            if (!found_d && req[cand[IDW-1:0]]) begin
                found_d = 1'b1;
                sel_d   = cand[IDW-1:0];
            end
        end
        nxt = {1'b0, sel_d} + (IDW+1)'(1);
        if (nxt == (IDW+1)'(NREQ))
            nxt = '0;
        ptr_d   = found_d ? nxt[IDW-1:0] : ptr_q;
        grant_d = found_d ? (NREQ'(1) << sel_d) : '0;
    end

    // Tag stage LATENCY lines up with the product appearing on mul_out.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ptr_q      <= '0;
            grant_q    <= '0;
            mulIn1_q   <= '0;
            mulIn2_q   <= '0;
            resData_q  <= '0;
            resValid_q <= 1'b0;
            resId_q    <= '0;
            tagV_q     <= '0;
            for (int s = 0; s <= LATENCY; s++)
                tagId_q[s] <= '0;
        end else begin
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            if (found_d) begin
                mulIn1_q <= opA[sel_d];
                mulIn2_q <= opB[sel_d];
            end
            tagV_q[0]  <= found_d;
            tagId_q[0] <= sel_d;
            for (int s = 1; s <= LATENCY; s++) begin
                tagV_q[s]  <= tagV_q[s-1];
                tagId_q[s] <= tagId_q[s-1];
            end
            resValid_q <= tagV_q[LATENCY];
            if (tagV_q[LATENCY]) begin
                resData_q <= mul_out;
                resId_q   <= tagId_q[LATENCY];
            end
        end
    end

    assign grant     = grant_q;
    assign mul_in1   = mulIn1_q;
    assign mul_in2   = mulIn2_q;
    assign res_data  = resData_q;
    assign res_valid = resValid_q;
    assign res_id    = resId_q;

endmodule

// File: tb/tb_mult_scheduler.sv
// Bench for mult_scheduler with a two-stage signed multiplier attached; a small
// round-robin model with a result-age pipeline predicts every output each cycle.
module tb_mult_scheduler;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [3:0]  req = '0;
    logic [63:0] in1 = '0;
    logic [63:0] in2 = '0;
    logic [3:0]  grant;
    logic [15:0] mul_in1, mul_in2;
    logic [15:0] mul_out = '0;
    logic [15:0] res_data;
    logic        res_valid;
    logic [1:0]  res_id;

    int checks = 0;
    int errors = 0;

    mult_scheduler #(.BITSIZE(16), .NREQ(4), .LATENCY(2)) dut (
        .clk(clk), .resetn(resetn), .req(req), .in1(in1), .in2(in2),
        .grant(grant), .mul_in1(mul_in1), .mul_in2(mul_in2), .mul_out(mul_out),
        .res_data(res_data), .res_valid(res_valid), .res_id(res_id)
    );

    always #5 clk = ~clk;

    // Shared multiplier: two registered stages, keeps the top half of the signed product.
    logic signed [31:0] prodStage = '0;
    always @(posedge clk) begin
        prodStage <= $signed(mul_in1) * $signed(mul_in2);
        mul_out   <= prodStage[31:16];
    end

    int          ptr = 0;
    logic [15:0] expIn1 = '0, expIn2 = '0, lastData = '0;
    logic        histV [3];
    logic [1:0]  histId [3];
    logic [15:0] histProd [3];
    int          grantCount = 0, resCount = 0;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic clearModel();
        ptr = 0; expIn1 = '0; expIn2 = '0; lastData = '0;
        for (int i = 0; i < 3; i++) begin
            histV[i] = 1'b0; histId[i] = '0; histProd[i] = '0;
        end
    endtask

    task automatic applyStimulus(input logic [3:0] reqv, input logic [63:0] a, input logic [63:0] b);
        int sel, idx;
        logic [3:0] expGrant;
        logic signed [31:0] p;
        logic [15:0] newProd;
        req = reqv; in1 = a; in2 = b;
        sel = -1;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (sel < 0 && reqv[idx]) sel = idx;
        end
        @(posedge clk); @(negedge clk);
        expGrant = '0;
        newProd = '0;
        if (sel >= 0) begin
            expGrant = 4'b0001 << sel;
            expIn1 = a[sel*16 +: 16];
            expIn2 = b[sel*16 +: 16];
            ptr = (sel + 1) % 4;
            p = $signed(expIn1) * $signed(expIn2);
            newProd = p[31:16];
        end
        checkOutput("grant", grant, expGrant);
        checkOutput("mul_in1", mul_in1, expIn1);
        checkOutput("mul_in2", mul_in2, expIn2);
        if (grant != 4'b0) grantCount++;
        checkOutput("res_valid", res_valid, histV[2]);
        if (histV[2]) begin
            checkOutput("res_id", res_id, histId[2]);
            checkOutput("res_data", res_data, histProd[2]);
            lastData = histProd[2];
        end else begin
            checkOutput("res_hold", res_data, lastData);
        end
        if (res_valid) resCount++;
        for (int i = 2; i > 0; i--) begin
            histV[i] = histV[i-1]; histId[i] = histId[i-1]; histProd[i] = histProd[i-1];
        end
        histV[0] = (sel >= 0);
        histId[0] = (sel >= 0) ? sel[1:0] : 2'd0;
        histProd[0] = newProd;
    endtask

    task automatic doReset();
        resetn = 1'b0; req = '0;
        @(posedge clk); @(negedge clk);
        checkOutput("rst_grant", grant, 0);
        checkOutput("rst_mul_in1", mul_in1, 0);
        checkOutput("rst_mul_in2", mul_in2, 0);
        checkOutput("rst_res_valid", res_valid, 0);
        checkOutput("rst_res_data", res_data, 0);
        checkOutput("rst_res_id", res_id, 0);
        resetn = 1'b1;
        clearModel();
    endtask

    initial begin
        clearModel();
        @(negedge clk);
        doReset();

        // Single request: 0.5 * 0.5 in Q15 gives 0x1000.
        applyStimulus(4'b0001, 64'h0000_0000_0000_4000, 64'h0000_0000_0000_4000);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);
        checkOutput("r029_data", res_data, 32'h1000);
        checkOutput("r029_id", res_id, 0);

        // All requesters held: strict rotation.
        doReset();
        for (int i = 0; i < 8; i++)
            applyStimulus(4'b1111, 64'h0004_0003_0002_0001 << (i*2), 64'h7000_6000_5000_4000);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);

        applyStimulus(4'b0100, 64'h0000_8000_0000_0000, 64'h0000_4000_0000_0000);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);
        checkOutput("r031a_data", res_data, 32'hE000);
        checkOutput("r031a_id", res_id, 2);
        applyStimulus(4'b1000, 64'h7FFF_0000_0000_0000, 64'h7FFF_0000_0000_0000);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);
        checkOutput("r031b_data", res_data, 32'h3FFF);
        checkOutput("r031b_id", res_id, 3);

        // Pointer wrap: after granting 1, requesters 0 and 1 pending must pick 0.
        doReset();
        applyStimulus(4'b0010, 64'h0000_0000_1234_0000, 64'h0000_0000_2000_0000);
        applyStimulus(4'b0011, 64'h0000_0000_0100_0200, 64'h0000_0000_0300_0400);
        checkOutput("r032_grant", grant, 4'b0001);
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);

        // Reset with two operations in flight: nothing may emerge afterwards.
        applyStimulus(4'b0001, 64'h0000_0000_0000_4000, 64'h0000_0000_0000_4000);
        applyStimulus(4'b0010, 64'h0000_0000_4000_0000, 64'h0000_0000_4000_0000);
        doReset();
        for (int i = 0; i < 4; i++) applyStimulus(4'b0000, '0, '0);

        // Random traffic against the model, then count balance after draining.
        grantCount = 0; resCount = 0;
        for (int i = 0; i < 1000; i++)
            applyStimulus(4'($urandom_range(0, 15)), {$urandom, $urandom}, {$urandom, $urandom});
        for (int i = 0; i < 3; i++) applyStimulus(4'b0000, '0, '0);
        checkOutput("r034_counts", resCount, grantCount);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mult_scheduler.md
MULT_SCHEDULER -- requirements
Module: mult_scheduler

Interface
REQ-001 Parameter BITSIZE, default 16, SHALL set the operand/result width in bits.
REQ-002 Parameter NREQ, default 4, SHALL set the number of requesters (2..8).
REQ-003 Parameter LATENCY, default 2, SHALL equal the clock-edge latency of the shared multiplier from mul_in1/mul_in2 to mul_out.
REQ-004 clk  input  1  single system clock; all state SHALL update on its rising edge only.
REQ-005 resetn  input  1  reset, synchronous and active-low.
REQ-006 req  input  NREQ  per-requester request level; bit i high means operands of requester i are valid.
REQ-007 in1  input  NREQ*BITSIZE  signed operand A, requester i at bits [i*BITSIZE +: BITSIZE].
REQ-008 in2  input  NREQ*BITSIZE  signed operand B, same packing as in1.
REQ-009 grant  output  NREQ  registered one-hot, one-cycle pulse: operands of requester i were accepted.
REQ-010 mul_in1  output  BITSIZE  registered operand A to the shared multiplier.
REQ-011 mul_in2  output  BITSIZE  registered operand B to the shared multiplier.
REQ-012 mul_out  input  BITSIZE  signed product (top BITSIZE bits of the 2*BITSIZE product) from the shared multiplier.
REQ-013 res_data  output  BITSIZE  registered result.
REQ-014 res_valid  output  1  one-cycle pulse; res_data/res_id valid.
REQ-015 res_id  output  max(1,clog2(NREQ))  index of the requester owning res_data.

Function
REQ-016 At each rising edge with resetn high and req nonzero, the block SHALL select exactly one requester by round-robin, starting the search at pointer p and wrapping modulo NREQ.
REQ-017 On selecting i: grant SHALL be one-hot bit i for the following cycle only; mul_in1/mul_in2 SHALL load requester i's in1/in2 slices; p SHALL become (i+1) mod NREQ.
REQ-018 With req all-zero: grant SHALL be 0, mul_in1/mul_in2 and p SHALL hold, and no operation SHALL be issued.
REQ-019 Arbitration SHALL use req and operands as sampled at the issuing edge; a req bit that drops at that edge SHALL not be granted.
REQ-020 A requester holding req high SHALL receive a new grant on each win; each grant is one independent operation (the requester drops req or updates operands in the cycle grant is seen).
REQ-021 Throughput SHALL be one issue per cycle; with all req high, each requester SHALL be granted exactly once every NREQ cycles (no starvation).
REQ-022 A tag pipeline of LATENCY+1 stages ({valid, id}) SHALL track each issue; res_data SHALL capture mul_out when the final stage is valid.
REQ-023 res_valid SHALL pulse exactly LATENCY+1 cycles after the corresponding grant pulse, with res_id = granted index; results SHALL return in issue order, one per cycle at most.
REQ-024 res_data SHALL hold its last value when res_valid is low.
REQ-025 The block SHALL not modify, saturate or round mul_out; the arithmetic belongs to the multiplier.

Reset
REQ-026 With resetn low at a rising edge: grant=0, mul_in1=0, mul_in2=0, res_valid=0, res_data=0, res_id=0, p=0, all tag stages invalid.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight operations; no res_valid SHALL appear for them after reset is released.
REQ-028 The first edge after resetn rises SHALL arbitrate normally with requester 0 at highest priority.

Verification (bench: BITSIZE=16, NREQ=4, LATENCY=2, real shared multiplier attached)
REQ-029 req=0001, in1[0]=0x4000, in2[0]=0x4000 for one cycle -> grant=0001 next cycle; res_valid 3 cycles after grant, res_data=0x1000, res_id=0.
REQ-030 req=1111 held 8 cycles after reset -> grant sequence 0001,0010,0100,1000,0001,...; 8 res_valid pulses, ids 0,1,2,3,0,1,2,3.
REQ-031 req[2] only, in1=0x8000, in2=0x4000 -> res_data=0xE000, res_id=2; then req[3] only, in1=0x7FFF, in2=0x7FFF -> res_data=0x3FFF, res_id=3.
REQ-032 Grant to requester 1, then req=0011 -> next grant goes to requester 0 (pointer wrap 2,3,0).
REQ-033 resetn low for 1 cycle while 2 operations are in flight -> no res_valid for them; all outputs 0 during reset.
REQ-034 req toggling randomly for 1000 cycles -> res_valid count equals grant count; ids and products match a reference model in issue order.
